// File: rtl/risc_program_loader.sv
// Program loader and run supervisor for Veri_Risc: streams bytes into memory, holds the CPU in reset, then times the run until halt.
// Optional run-cycle limit enabled by defining RISC_LOADER_TIMEOUT_EN.
module risc_program_loader #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int LOAD_WORDS   = 32,
    parameter int RESET_CYCLES = 1,
    parameter int CNT_WIDTH    = 16,
    parameter int MAX_CYCLES   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    input  logic                  cpu_halt,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  cycles,
    output logic                  timeout
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

    localparam int HOLD_WIDTH = $clog2(RESET_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LOAD_WORDS - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(RESET_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  CNT_SAT   = '1;

`ifdef RISC_LOADER_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0]  CNT_LIMIT = CNT_WIDTH'(MAX_CYCLES);
`else
    logic unused_max_cycles;
    assign unused_max_cycles = |MAX_CYCLES;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [HOLD_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    done_q, done_d;
    logic [CNT_WIDTH-1:0]    cycles_q, cycles_d;
    logic                    timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        done_d      = done_q;
        cycles_d    = cycles_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    ptr_d     = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = in_data;
                    ptr_d       = ptr_q + 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            S_HOLD: begin
                // The last write strobe retires on the first HOLD edge, so the CPU stays in reset through it.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = S_RUN;
                    cpu_rst_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (cpu_halt) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
`ifdef RISC_LOADER_TIMEOUT_EN
                else if (cycles_q == CNT_LIMIT) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    cpu_rst_d = 1'b1;
                end
`endif
                else if (cycles_q != CNT_SAT) begin
                    cycles_d = cycles_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            cycles_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            cycles_q    <= cycles_d;
            timeout_q   <= timeout_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign cycles    = cycles_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_risc_program_loader.sv
// Directed bench for risc_program_loader: a write scoreboard checks every memory strobe
// against the bytes the bench streamed in, plus reset, hold, run, halt and timeout checks.
module tb_risc_program_loader;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int LW = 32;
    localparam int RC = 1;
    localparam int CW = 16;
    localparam int MC = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_rst;
    logic          cpu_halt;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycles;
    logic          timeout;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_item;

    risc_program_loader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .LOAD_WORDS  (LW),
        .RESET_CYCLES(RC),
        .CNT_WIDTH   (CW),
        .MAX_CYCLES  (MC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst  (cpu_rst),
        .cpu_halt (cpu_halt),
        .busy     (busy),
        .done     (done),
        .cycles   (cycles),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every strobe must match the oldest byte the bench handed over while loading.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            wr_count++;
            checkOutput("wr_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) begin
                exp_item = exp_q.pop_front();
                checkOutput("wr_addr", 32'(mem_addr), 32'(exp_item[AW+DW-1:DW]));
                checkOutput("wr_data", 32'(mem_wdata), 32'(exp_item[DW-1:0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte for one clock; the bench expects it accepted at pointer idx.
    task automatic applyStimulus(input int idx, input logic [DW-1:0] data, input logic pulse_start);
        checkOutput("load_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        start    = pulse_start;
        exp_q.push_back({AW'(idx), data});
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_mem_we"},   32'(mem_we),   32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"},32'(mem_wdata),32'd0);
        checkOutput({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
        checkOutput({tag, "_busy"},     32'(busy),     32'd0);
        checkOutput({tag, "_done"},     32'(done),     32'd0);
        checkOutput({tag, "_cycles"},   32'(cycles),   32'd0);
        checkOutput({tag, "_timeout"},  32'(timeout),  32'd0);
    endtask

    task automatic fullLoad(input logic [DW-1:0] xor_key);
        for (int i = 0; i < LW; i++) begin
            applyStimulus(i, DW'(i) ^ xor_key, 1'b0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        cpu_halt = 1'b0;

        // Reset only: outputs at reset values, no writes while idle even with in_valid high.
        tick();
        tick();
        checkResetOutputs("rst");
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
        end
        checkOutput("idle_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;

        // Full-rate load of 0x00..0x1F, hold timing, 5-cycle run.
        pulseStart();
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_cpu_rst", 32'(cpu_rst), 32'd1);
        fullLoad(8'h00);
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        checkOutput("hold_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("hold_cpu_rst", 32'(cpu_rst), 32'd1);
        tick();
        checkOutput("run_cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("load1_writes", 32'(wr_count), 32'd32);
        checkOutput("load1_queue", 32'(exp_q.size()), 32'd0);
        repeat (5) tick();
        checkOutput("run_cycles_pre", 32'(cycles), 32'd5);
        checkOutput("run_done_pre", 32'(done), 32'd0);
        cpu_halt = 1'b1;
        tick();
        checkOutput("halt_cycles", 32'(cycles), 32'd5);
        checkOutput("halt_done", 32'(done), 32'd1);
        checkOutput("halt_busy", 32'(busy), 32'd0);
        checkOutput("halt_cpu_rst", 32'(cpu_rst), 32'd0);

        // Start with halt still high while in DONE restarts and clears the run status.
        pulseStart();
        cpu_halt = 1'b0;
        checkOutput("restart_cycles", 32'(cycles), 32'd0);
        checkOutput("restart_done", 32'(done), 32'd0);
        checkOutput("restart_cpu_rst", 32'(cpu_rst), 32'd1);

        // Half-rate stream with stray start pulses during LOAD.
        for (int i = 0; i < LW; i++) begin
            applyStimulus(i, DW'(i * 7 + 3), (i == 5) || (i == 20));
            tick();
        end
        checkOutput("slow_in_ready", 32'(in_ready), 32'd0);
        checkOutput("slow_cpu_rst", 32'(cpu_rst), 32'd1);
        tick();
        checkOutput("slow_run_cpu_rst", 32'(cpu_rst), 32'd0);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        checkOutput("slow_done", 32'(done), 32'd1);
        checkOutput("slow_cycles", 32'(cycles), 32'd0);
        checkOutput("load2_writes", 32'(wr_count), 32'd64);
        checkOutput("load2_queue", 32'(exp_q.size()), 32'd0);

        // Async reset after 10 accepted bytes, then a full reload from address 0.
        pulseStart();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i, DW'(i) ^ 8'hC3, 1'b0);
        end
        tick();
        rst = 1'b1;
        #1;
        checkResetOutputs("async");
        checkOutput("async_queue", 32'(exp_q.size()), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        pulseStart();
        fullLoad(8'h5A);
        tick();
        tick();
        repeat (3) tick();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        checkOutput("reload_cycles", 32'(cycles), 32'd3);
        checkOutput("reload_done", 32'(done), 32'd1);
        checkOutput("reload_writes", 32'(wr_count), 32'd106);

        // Runaway CPU: halt never rises; stray stream bytes during RUN must be ignored.
        pulseStart();
        fullLoad(8'hA5);
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 8'hEE;
`ifdef RISC_LOADER_TIMEOUT_EN
        repeat (MC) tick();
        checkOutput("to_cycles_pre", 32'(cycles), 32'(MC));
        checkOutput("to_busy_pre", 32'(busy), 32'd1);
        checkOutput("to_timeout_pre", 32'(timeout), 32'd0);
        tick();
        checkOutput("to_timeout", 32'(timeout), 32'd1);
        checkOutput("to_done", 32'(done), 32'd1);
        checkOutput("to_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("to_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        checkOutput("to_cycles", 32'(cycles), 32'(MC));
`else
        repeat (200) tick();
        checkOutput("norun_busy", 32'(busy), 32'd1);
        checkOutput("norun_done", 32'(done), 32'd0);
        checkOutput("norun_timeout", 32'(timeout), 32'd0);
        checkOutput("norun_cycles", 32'(cycles), 32'd200);
        checkOutput("norun_cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("norun_in_ready", 32'(in_ready), 32'd0);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        checkOutput("norun_halt_done", 32'(done), 32'd1);
        checkOutput("norun_halt_cycles", 32'(cycles), 32'd200);
`endif
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("final_writes", 32'(wr_count), 32'd138);
        checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_program_loader.md
# risc_program_loader

Program loader and run supervisor for the Veri_Risc CPU. It accepts a byte stream over a valid/ready handshake and writes it into the CPU's instruction/data memory through a write port. It holds the CPU in reset while loading, releases it, then counts clocks until the CPU asserts `halt`. It sits upstream of Veri_Risc and replaces bench-side memory preloading in system-level runs.

## Interface
- `ADDR_WIDTH`, 5: memory address width.
- `DATA_WIDTH`, 8: memory word and stream byte width.
- `LOAD_WORDS`, 32: words per load; must satisfy 1 ≤ LOAD_WORDS ≤ 2**ADDR_WIDTH.
- `RESET_CYCLES`, 1: clocks `cpu_rst` stays high after the last write; must be ≥ 1.
- `CNT_WIDTH`, 16: width of the run-cycle counter.
- `MAX_CYCLES`, 1000: timeout limit; used only with the timeout feature enabled.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — one-cycle request to begin a load/run sequence.
- `in_valid`  in  1  — stream byte valid.
- `in_data`  in  DATA_WIDTH  — stream byte.
- `in_ready`  out  1  — loader can accept a byte.
- `mem_we`  out  1  — memory write strobe.
- `mem_addr`  out  ADDR_WIDTH  — memory write address.
- `mem_wdata`  out  DATA_WIDTH  — memory write data.
- `cpu_rst`  out  1  — drives the CPU's `rst`.
- `cpu_halt`  in  1  — the CPU's `halt`.
- `busy`  out  1  — high in LOAD, HOLD and RUN.
- `done`  out  1  — run finished, sticky until the next start.
- `cycles`  out  CNT_WIDTH  — clocks counted during RUN.
- `timeout`  out  1  — run aborted by the limit; constant 0 when the feature is compiled out.

## Operation
- States: IDLE, LOAD, HOLD, RUN, DONE. All outputs are registered except `in_ready` and `busy`, which decode the state.
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_rst` 1, `busy` 0, `done` 0, `cycles` 0, `timeout` 0.
- IDLE or DONE with `start` high → LOAD. The same edge does all of the following:
  - sets `cpu_rst` to 1;
  - clears `done`, `cycles` and `timeout`;
  - clears the write pointer to 0.
- `start` is ignored in LOAD, HOLD and RUN.
- LOAD:
  - `in_ready` is 1.
  - A byte is accepted on each edge where `in_valid && in_ready`.
  - The edge after acceptance, `mem_we` is 1 with `mem_addr` set to the pointer and `mem_wdata` set to the byte. The pointer then increments.
  - `mem_we` is 0 on edges with no acceptance.
  - Addresses are written strictly 0..LOAD_WORDS-1 in order, with no skips or repeats.
  - The edge accepting byte LOAD_WORDS-1 moves to HOLD; `in_ready` is 0 from then on.
- HOLD:
  - `cpu_rst` stays 1 for RESET_CYCLES edges; the final write strobe lands in the first of these.
  - Then → RUN, and `cpu_rst` goes to 0 on that edge.
- RUN:
  - On each edge, if `cpu_halt` is 0, `cycles` increments, saturating at all-ones.
  - The first edge sampling `cpu_halt` = 1 → DONE with `done` = 1. `cycles` does not increment on that edge.
- DONE: `cpu_rst` stays 0 so the CPU remains halted and its state stays observable. `done` holds until `start`.
- `in_valid` is ignored outside LOAD.
- Asynchronous reset at any point returns every output to its reset value immediately. Memory already written keeps its contents, and the next `start` reloads from address 0.

## Timing
- Write latency: one clock from acceptance to `mem_we`.
- Full-rate stream: LOAD lasts exactly LOAD_WORDS clocks.
- From the last acceptance edge to the `cpu_rst` fall edge: RESET_CYCLES+1 edges.
- From the halt-sampling edge to `done`: asserted on that same edge.
- `start` coincident with `rst`: reset wins.
- `start` and `cpu_halt` in the same cycle while in DONE: LOAD is entered.

## Configuration
- `RISC_LOADER_TIMEOUT_EN` defined:
  - In RUN, if `cycles` reaches MAX_CYCLES with `cpu_halt` still 0, the next edge goes to DONE.
  - That edge sets `timeout` = 1, `done` = 1 and `cpu_rst` = 1, holding the runaway CPU in reset.
  - `cycles` freezes at MAX_CYCLES.
- `RISC_LOADER_TIMEOUT_EN` undefined: no limit logic. `timeout` is tied to 0, and RUN lasts until halt with `cycles` saturating.

## Test plan
- Reset only → all outputs at their reset values (`cpu_rst` = 1, `cycles` = 0), and no `mem_we` for 10 clocks.
- `start`, then 32 full-rate bytes 0x00..0x1F → 32 strobes with `mem_addr` = `mem_wdata` = 0..31 in order, and `in_ready` low after the 32nd acceptance. With RESET_CYCLES = 1, `cpu_rst` falls 2 edges after the last acceptance.
- Halt stub holds `cpu_halt` = 0 for 5 RUN edges, then 1 → `cycles` = 5, `done` = 1, `busy` = 0. A second `start` clears `cycles` to 0.
- `in_valid` high every other cycle, with `start` pulsed during LOAD → 32 writes in order with no duplicates; `start` has no effect.
- Async `rst` after 10 accepted bytes → outputs reset immediately. The next `start` rewrites addresses starting at 0.
- Timeout, with `RISC_LOADER_TIMEOUT_EN` and MAX_CYCLES = 100, `cpu_halt` stuck at 0 → `cycles` = 100, `timeout` = 1, `done` = 1, `cpu_rst` = 1. Built without the macro → still in RUN after 200 clocks, and `timeout` = 0.
